// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared widths, FSM encodings and constants for the Montgomery exponentiator
//
// Contents:
//   OPERAND_W    width of modulus / operands / products
//   MONT_R_LOG2  log2 of the Montgomery radix R (number of multiplier iterations)
//   ACC_W        multiplier accumulator width (holds values below 4*M)
//   exp_state_t  exponentiation sequencer states
//   mm_phase_t   per-multiplication handshake phases
//   ONE_1024     constant 1, used to leave the Montgomery domain
package mont_pkg;

    localparam int OPERAND_W   = 1024;
    localparam int MONT_R_LOG2 = 1024;
    localparam int ACC_W       = OPERAND_W + 2;
    localparam int ITER_W      = $clog2(MONT_R_LOG2);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SQ,
        MUL,
        POST,
        DONE
    } exp_state_t;

    // ISSUE: mult_start high; GUARD: ignore a stale done; SAMPLE: wait for done
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_GUARD,
        PH_SAMPLE
    } mm_phase_t;

    localparam logic [OPERAND_W-1:0] ONE_1024 = OPERAND_W'(1);

    function automatic logic is_mm_state(input exp_state_t s);
        return (s == PRE) || (s == SQ) || (s == MUL) || (s == POST);
    endfunction

endpackage

// File: rtl/montgomery.sv
// rtl/montgomery.sv - bit-serial Montgomery multiplier, product = a*b*R^-1 mod m, R = 2^MONT_R_LOG2
//
// Ports:
//   clk      in   clock
//   resetn   in   synchronous active-low reset
//   start    in   one-cycle pulse; captures a, b, m and restarts the core
//   a, b     in   operands, expected < m
//   m        in   odd modulus
//   product  out  result, valid while done is high
//   done     out  level; rises when product is valid, stays high until the next start
module montgomery
    import mont_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic [OPERAND_W-1:0] m,
    output logic [OPERAND_W-1:0] product,
    output logic                 done
);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MONT_R_LOG2 - 1);

    logic [OPERAND_W-1:0] a_sh;
    logic [OPERAND_W-1:0] b_r;
    logic [OPERAND_W-1:0] m_r;
    logic [ACC_W-1:0]     acc;
    logic [ITER_W-1:0]    iter;
    logic                 running;
    logic                 finish;

    logic [ACC_W-1:0]     b_ext;
    logic [ACC_W-1:0]     m_ext;
    logic [ACC_W-1:0]     add_b;
    logic [ACC_W-1:0]     add_m;
    logic [ACC_W-1:0]     acc_next;
    logic [OPERAND_W-1:0] reduced;

    // One radix-2 step: acc = (acc + a_i*b + q*m) / 2 with q chosen to make
    // the sum even. With a, b < m the accumulator stays below 2m between
    // steps, so the sum never reaches 4m and ACC_W bits are enough.
    always_comb begin
        b_ext    = {2'b00, b_r};
        m_ext    = {2'b00, m_r};
        add_b    = acc + (a_sh[0] ? b_ext : '0);
        add_m    = add_b[0] ? (add_b + m_ext) : add_b;
        acc_next = add_m >> 1;
        reduced  = (acc >= m_ext) ? OPERAND_W'(acc - m_ext) : acc[OPERAND_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_sh    <= '0;
            b_r     <= '0;
            m_r     <= '0;
            acc     <= '0;
            iter    <= '0;
            running <= 1'b0;
            finish  <= 1'b0;
            product <= '0;
            done    <= 1'b0;
        end else if (start) begin
            a_sh    <= a;
            b_r     <= b;
            m_r     <= m;
            acc     <= '0;
            iter    <= '0;
            running <= 1'b1;
            finish  <= 1'b0;
            done    <= 1'b0;
        end else if (running) begin
            acc  <= acc_next;
            a_sh <= a_sh >> 1;
            iter <= iter + ITER_W'(1);
            if (iter == LAST_ITER) begin
                running <= 1'b0;
                finish  <= 1'b1;
            end
        end else if (finish) begin
            // final conditional subtraction brings the result below m
            product <= reduced;
            done    <= 1'b1;
            finish  <= 1'b0;
        end
    end

endmodule

// File: rtl/montgomery_exp.sv
// rtl/montgomery_exp.sv - modular exponentiation controller, result = in_x^in_e mod in_m
//
// Left-to-right square-and-multiply carried out in the Montgomery domain on
// a single internal bit-serial Montgomery multiplier.
//
// Ports:
//   clk       in   clock
//   resetn    in   synchronous active-low reset
//   start     in   one-cycle pulse, accepted only when idle; latches all operands
//   in_x      in   base, < in_m
//   in_e      in   exponent
//   in_e_len  in   significant exponent bits t (clamped to EXP_WIDTH)
//   in_m      in   odd modulus
//   in_r      in   R mod M
//   in_r2     in   R^2 mod M
//   result    out  x^e mod M, valid while done is high and held afterwards
//   busy      out  high while an operation is in flight
//   done      out  one-cycle completion pulse
module montgomery_exp
    import mont_pkg::*;
#(
    parameter int EXP_WIDTH = 1024,
    parameter int LEN_W     = $clog2(EXP_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]     in_e_len,
    input  logic [OPERAND_W-1:0] in_m,
    input  logic [OPERAND_W-1:0] in_r,
    input  logic [OPERAND_W-1:0] in_r2,
    output logic [OPERAND_W-1:0] result,
    output logic                 busy,
    output logic                 done
);

    localparam int               IDX_W = $clog2(EXP_WIDTH);
    localparam logic [LEN_W-1:0] T_MAX = LEN_W'(EXP_WIDTH);

    exp_state_t           state;
    exp_state_t           state_next;
    mm_phase_t            phase;

    logic [OPERAND_W-1:0] x_r;
    logic [EXP_WIDTH-1:0] e_r;
    logic [OPERAND_W-1:0] m_r;
    logic [OPERAND_W-1:0] r2_r;
    logic [OPERAND_W-1:0] a_r;
    logic [OPERAND_W-1:0] xt_r;
    logic [IDX_W-1:0]     bit_idx;
    logic                 t_zero;

    logic [LEN_W-1:0]     t_eff;
    logic                 accept;
    logic                 capture;
    logic                 last_bit;
    logic                 cur_bit;

    logic                 mult_start;
    logic                 mm_done;
    logic [OPERAND_W-1:0] mm_product;
    logic [OPERAND_W-1:0] op_a;
    logic [OPERAND_W-1:0] op_b;

    montgomery u_mult (
        .clk     (clk),
        .resetn  (resetn),
        .start   (mult_start),
        .a       (op_a),
        .b       (op_b),
        .m       (m_r),
        .product (mm_product),
        .done    (mm_done)
    );

    // The multiplier's done is a level that survives from the previous
    // product, so it is only trusted once the guard cycle has passed.
    always_comb begin
        t_eff    = (in_e_len > T_MAX) ? T_MAX : in_e_len;
        accept   = (state == IDLE) && start;
        capture  = is_mm_state(state) && (phase == PH_SAMPLE) && mm_done;
        last_bit = (bit_idx == '0);
        cur_bit  = e_r[bit_idx];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero exponent bit returns SQ to itself for the next bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)   state_next = PRE;
            PRE:  if (capture) state_next = t_zero ? POST : SQ;
            SQ:   if (capture) state_next = cur_bit ? MUL : (last_bit ? POST : SQ);
            MUL:  if (capture) state_next = last_bit ? POST : SQ;
            POST: if (capture) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and operand muxes; operands depend only on state and registers,
    // so they stay stable from the issue cycle through the capture cycle.
    always_comb begin
        mult_start = is_mm_state(state) && (phase == PH_ISSUE);
        busy       = is_mm_state(state);
        done       = (state == DONE);
        op_a       = (state == PRE) ? x_r : a_r;
        case (state)
            PRE:     op_b = r2_r;
            SQ:      op_b = a_r;
            MUL:     op_b = xt_r;
            POST:    op_b = ONE_1024;
            default: op_b = a_r;
        endcase
    end

    // Handshake phase, operand registers, bit index and result
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase   <= PH_ISSUE;
            x_r     <= '0;
            e_r     <= '0;
            m_r     <= '0;
            r2_r    <= '0;
            a_r     <= '0;
            xt_r    <= '0;
            bit_idx <= '0;
            t_zero  <= 1'b0;
            result  <= '0;
        end else begin
            // A capture always restarts the phase, even when SQ repeats.
            if (is_mm_state(state) && !capture) begin
                case (phase)
                    PH_ISSUE: phase <= PH_GUARD;
                    PH_GUARD: phase <= PH_SAMPLE;
                    default:  phase <= PH_SAMPLE;
                endcase
            end else begin
                phase <= PH_ISSUE;
            end

            if (accept) begin
                x_r     <= in_x;
                e_r     <= in_e;
                m_r     <= in_m;
                r2_r    <= in_r2;
                a_r     <= in_r;
                t_zero  <= (t_eff == '0);
                bit_idx <= IDX_W'(t_eff - LEN_W'(1));
            end

            if (capture) begin
                case (state)
                    PRE:     xt_r <= mm_product;
                    SQ:      a_r  <= mm_product;
                    MUL:     a_r  <= mm_product;
                    // loaded on entry to DONE so it is valid during the done pulse
                    POST:    result <= mm_product;
                    default: ;
                endcase
                if (((state == SQ) && !cur_bit && !last_bit) ||
                    ((state == MUL) && !last_bit)) begin
                    bit_idx <= bit_idx - IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_montgomery_exp.sv
// tb/tb_montgomery_exp.sv - self-checking scoreboard bench for montgomery_exp
module tb_montgomery_exp;
    import mont_pkg::*;

    localparam int EW = 1024;
    localparam int LW = $clog2(EW) + 1;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [1023:0]   in_x;
    logic [EW-1:0]   in_e;
    logic [LW-1:0]   in_e_len;
    logic [1023:0]   in_m;
    logic [1023:0]   in_r;
    logic [1023:0]   in_r2;
    logic [1023:0]   result;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;
    int mm_total = 0;
    int done_total = 0;
    int mm_base  = 0;
    int done_base = 0;

    logic [1023:0] exp_q[$];

    always #5 clk = ~clk;

    montgomery_exp #(.EXP_WIDTH(EW), .LEN_W(LW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .in_x     (in_x),
        .in_e     (in_e),
        .in_e_len (in_e_len),
        .in_m     (in_m),
        .in_r     (in_r),
        .in_r2    (in_r2),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    always @(negedge clk) begin
        if (resetn && dut.mult_start) mm_total++;
        if (done) done_total++;
    end

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed[127:0]=%0h expected[127:0]=%0h", tag, obs[127:0], expv[127:0]);
        end
    endtask

    function automatic logic [1023:0] modpow(input logic [1023:0] x, input logic [1023:0] e,
                                             input int t, input logic [1023:0] m);
        logic [2047:0] acc, base, mm;
        mm   = {1024'b0, m};
        acc  = 2048'(1) % mm;
        base = {1024'b0, x} % mm;
        for (int k = 0; k < t; k++) begin
            if (e[k]) acc = (acc * base) % mm;
            base = (base * base) % mm;
        end
        return acc[1023:0];
    endfunction

    function automatic int mm_expected(input logic [1023:0] e, input int t);
        logic [1023:0] mask;
        mask = (1024'(1) << t) - 1024'(1);
        return 2 + t + $countones(e & mask);
    endfunction

    task automatic drive_start(input logic [1023:0] x, input logic [1023:0] e, input logic [LW-1:0] t,
                               input logic [1023:0] m, input logic [1023:0] r, input logic [1023:0] r2);
        in_x = x; in_e = e; in_e_len = t; in_m = m; in_r = r; in_r2 = r2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(input string tag, input logic [1023:0] x, input logic [1023:0] e,
                          input logic [LW-1:0] t, input logic [1023:0] m, input logic [1023:0] r,
                          input logic [1023:0] r2, input logic [1023:0] expv);
        mm_base   = mm_total;
        done_base = done_total;
        exp_q.push_back(expv);
        drive_start(x, e, t, m, r, r2);
        check({tag, " busy_after_accept"}, 1024'(busy), 1024'(1));
    endtask

    task automatic collect(input string tag, input int exp_mm);
        bit            got = 1'b0;
        logic [1023:0] expv = '0;
        int            budget = exp_mm * 1100 + 100;
        for (int c = 0; c < budget && !got; c++) begin
            if (done === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, " done_seen"}, 1024'(got), 1024'(1));
        check({tag, " sb_nonempty"}, 1024'(exp_q.size() != 0), 1024'(1));
        if (exp_q.size() != 0) expv = exp_q.pop_front();
        if (got) begin
            check({tag, " result"}, result, expv);
            check({tag, " busy_at_done"}, 1024'(busy), 1024'(0));
        end
        @(negedge clk);
        check({tag, " done_one_cycle"}, 1024'(done), 1024'(0));
        @(negedge clk);
        check({tag, " result_held"}, result, expv);
        check({tag, " mm_count"}, 1024'(mm_total - mm_base), 1024'(exp_mm));
        check({tag, " done_count"}, 1024'(done_total - done_base), 1024'(1));
    endtask

    logic [1023:0] m4, x4, r4, r24, e4, xr;
    logic [2047:0] wide;
    int            d_snap;
    bit            reached;

    initial begin
        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_e = '0; in_e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
        repeat (3) @(negedge clk);
        check("reset result", result, '0);
        check("reset busy", 1024'(busy), 1024'(0));
        check("reset done", 1024'(done), 1024'(0));
        resetn = 1'b1;
        @(negedge clk);

        // 1: 2^5 mod 11
        launch("t1", 1024'd2, 1024'd5, LW'(3), 1024'd11, 1024'd5, 1024'd3, 1024'd10);
        collect("t1", mm_expected(1024'd5, 3));

        // 2: t=0 ignores the exponent entirely
        launch("t2", 1024'd2, 1024'hFF, LW'(0), 1024'd11, 1024'd5, 1024'd3, 1024'd1);
        collect("t2", mm_expected(1024'hFF, 0));

        // 3: 7^1 mod 11
        launch("t3", 1024'd7, 1024'd1, LW'(1), 1024'd11, 1024'd5, 1024'd3, 1024'd7);
        collect("t3", mm_expected(1024'd1, 1));

        // e=0 with t>0: squares of R only
        launch("e0", 1024'd2, 1024'd0, LW'(2), 1024'd11, 1024'd5, 1024'd3, 1024'd1);
        collect("e0", mm_expected(1024'd0, 2));

        // 4: random 1024-bit odd modulus, e=65537
        for (int k = 0; k < 32; k++) begin
            m4[k*32 +: 32] = $urandom();
            xr[k*32 +: 32] = $urandom();
        end
        m4[1023] = 1'b1;
        m4[0]    = 1'b1;
        x4   = xr % m4;
        wide = (2048'(1) << 1024) % {1024'b0, m4};
        r4   = wide[1023:0];
        wide = ({1024'b0, r4} * {1024'b0, r4}) % {1024'b0, m4};
        r24  = wide[1023:0];
        e4   = 1024'd65537;
        launch("t4", x4, e4, LW'(17), m4, r4, r24, modpow(x4, e4, 17, m4));
        collect("t4", mm_expected(e4, 17));

        // 5: second start mid-run must be ignored
        launch("t5", 1024'd2, 1024'd5, LW'(3), 1024'd11, 1024'd5, 1024'd3, 1024'd10);
        repeat (40) @(negedge clk);
        drive_start(1024'd3, 1024'd7, LW'(3), 1024'd13, 1024'd3, 1024'd9);
        check("t5 busy_after_repulse", 1024'(busy), 1024'(1));
        collect("t5", mm_expected(1024'd5, 3));

        // 6: reset during SQ, then a clean rerun with junk above bit t-1
        launch("t6a", 1024'd2, 1024'd5, LW'(3), 1024'd11, 1024'd5, 1024'd3, 1024'd10);
        reached = 1'b0;
        for (int c = 0; c < 3000 && !reached; c++) begin
            if (dut.state == SQ) reached = 1'b1;
            else @(negedge clk);
        end
        check("t6 reached_sq", 1024'(reached), 1024'(1));
        resetn = 1'b0;
        @(negedge clk);
        check("t6 rst busy", 1024'(busy), 1024'(0));
        check("t6 rst done", 1024'(done), 1024'(0));
        check("t6 rst result", result, '0);
        resetn = 1'b1;
        exp_q.delete();
        d_snap = done_total;
        repeat (3) @(negedge clk);
        check("t6 no_done_after_rst", 1024'(done_total - d_snap), 1024'(0));
        launch("t6b", 1024'd2, 1024'hF5, LW'(3), 1024'd11, 1024'd5, 1024'd3, 1024'd10);
        collect("t6b", mm_expected(1024'hF5, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
